program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Sequences the CPU control block through its programming mode to load a program into the 16x8 RAM, then releases the CPU to run.
//  - Collects a program byte-stream from the host (valid/ready) into a local buffer.
//  - Holds the CPU in reset, then drives programming=1 and feeds one byte onto the bus per read_ui_in/done_load cycle.
//  - Resets the CPU again and lets it execute; reports halt and stall errors.
// PARAMETERS
//  DEPTH       16  program words; equals RAM size
//  ADDR_W      4   log2(DEPTH)
//  DATA_W      8   bus/RAM word width
//  RST_CYCLES  2   cycles cpu_resetn is held low per CPU reset (min 2)
//  TIMEOUT     64  max cycles between done_load pulses in PROGRAM
// PORTS
//  clk             in   1       system clock; all state changes on posedge
//  resetn          in   1       synchronous, active-low reset
//  start           in   1       1-cycle pulse: begin a new load (any state)
//  in_valid        in   1       host byte valid
//  in_data         in   DATA_W  host byte (instruction/data word)
//  in_last         in   1       marks final host byte; qualified by in_valid
//  in_ready        out  1       loader accepts the byte this cycle
//  cpu_ready       in   1       control block ready (stage T0)
//  cpu_read_ui_in  in   1       control block requests the next bus byte
//  cpu_done_load   in   1       control block wrote the RAM word
//  cpu_hf          in   1       control block halt flag
//  programming     out  1       puts the control block in programming mode
//  cpu_resetn      out  1       active-low reset to the CPU core
//  bus_drive       out  1       loader owns the bus (tri-state/mux enable)
//  bus_data        out  DATA_W  byte driven onto the bus
//  load_count      out  ADDR_W+1  bytes accepted from the host (0..DEPTH)
//  busy            out  1       high in FILL, PRE_RST, PROGRAM and POST_RST
//  halted          out  1       CPU halted after a successful run
//  error           out  1       watchdog expired in PROGRAM
// BEHAVIOUR
//  Reset values: state=IDLE, in_ready=0, programming=0, cpu_resetn=0, bus_drive=0, bus_data=0, load_count=0, busy=halted=error=0.
//  FSM: IDLE, FILL, PRE_RST, PROGRAM, POST_RST, RUN, HALTED, ERROR.
//  start has priority in every state:
//   - load_count<=0, buffer cleared to 0x00, -> FILL.
//   - If start arrives in PROGRAM, programming drops the next cycle.
//  IDLE: CPU held in reset; in_valid ignored.
//  FILL:
//   - in_ready = (load_count<DEPTH).
//   - Accept on in_valid&&in_ready: buf[load_count]<=in_data, load_count++.
//   - Exit to PRE_RST after accepting a byte with in_last=1, or when load_count reaches DEPTH.
//   - in_last with load_count==0 is impossible by construction; the first accepted byte counts.
//  PRE_RST: programming=1, cpu_resetn=0 for RST_CYCLES cycles, then -> PROGRAM.
//  PROGRAM: programming=1, cpu_resetn=1, wr_idx starts at 0.
//   - bus_drive=cpu_read_ui_in (combinational).
//   - bus_data = buf[wr_idx] when bus_drive, else 0.
//   - All DEPTH words are always written; entries >= load_count read 0x00 (HLT pad).
//   - Posedge with cpu_done_load=1: wr_idx++, watchdog cleared.
//   - done_load on word DEPTH-1 -> POST_RST.
//   - Watchdog counts cycles without done_load; at TIMEOUT -> ERROR.
//   - cpu_hf ignored in this state.
//  POST_RST: programming=0, cpu_resetn=0 for RST_CYCLES cycles, then -> RUN.
//  RUN: cpu_resetn=1, programming=0; cpu_hf=1 -> HALTED.
//  HALTED: halted=1, cpu_resetn=1 (CPU output retained); waits for start.
//  ERROR: error=1, cpu_resetn=0, programming=0; waits for start.
//  resetn low mid-operation: back to IDLE the next posedge; buffer contents don't care.
//  All outputs except bus_drive/bus_data are registered.
//  Word order: address k receives the k-th accepted host byte.
// STRUCTURE
//  Shared package loader_pkg: state enum and encodings, PRE/POST reset-length and watchdog constants shared with the top-level bench.
//  Sub-module program_buffer: DEPTH x DATA_W register file with
//   - one write port (FILL);
//   - one asynchronous read port with a bound check (idx >= count reads 0).
//  FSM, wr_idx, reset-length and watchdog counters stay in program_loader.
// TESTING
//  1. start, 3 bytes {0x4E,0x5F,0x00} (last on 3rd) with the real control block.
//     -> RAM[0..2] = {0x4E,0x5F,0x00}; RAM[3..15] = 0x00.
//     -> exactly 16 done_load pulses, then POST_RST; RUN, then HALTED once HF rises.
//  2. 16 bytes with in_last never asserted.
//     -> in_ready drops after the 16th accept; load_count=16; a 17th in_valid is not accepted.
//  3. in_valid toggling every other cycle during FILL.
//     -> only handshaked bytes are stored; bus_data during word k equals the k-th stored byte.
//  4. Model stalls done_load after word 5.
//     -> error=1 exactly TIMEOUT cycles after the last done_load; cpu_resetn=0, programming=0.
//  5. start pulse mid-PROGRAM (word 7).
//     -> programming=0 the next cycle, state FILL, load_count=0, in_ready=1.
//  6. resetn low for 1 cycle during RUN.
//     -> every output at its reset value the following cycle; cpu_resetn=0.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: constants and state encoding shared by program_loader, its
// program_buffer sub-module and the top-level bench.
//   DEPTH/ADDR_W/DATA_W : program size and bus/RAM word geometry
//   RST_CYCLES          : cycles cpu_resetn is held low per CPU reset
//   TIMEOUT             : max cycles between done_load pulses in PROGRAM
//   state_t             : loader sequencing states
package loader_pkg;

    localparam int unsigned DEPTH      = 16;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned RST_CYCLES = 2;
    localparam int unsigned TIMEOUT    = 64;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_PRE_RST  = 3'd2,
        S_PROGRAM  = 3'd3,
        S_POST_RST = 3'd4,
        S_RUN      = 3'd5,
        S_HALTED   = 3'd6,
        S_ERROR    = 3'd7
    } state_t;

endpackage

// File: rtl/program_buffer.sv
// program_buffer: DEPTH x DATA_W program store filled from the host stream.
//   clk      in  system clock
//   i_clr    in  clear every entry to 0x00 (takes priority over write)
//   i_we     in  write enable
//   i_waddr  in  write address
//   i_wdata  in  write data
//   i_raddr  in  asynchronous read address
//   i_count  in  number of valid entries; reads at or beyond it return 0x00
//   o_rdata  out read data
module program_buffer
    import loader_pkg::*;
#(
    parameter int unsigned P_DEPTH  = DEPTH,
    parameter int unsigned P_ADDR_W = ADDR_W,
    parameter int unsigned P_DATA_W = DATA_W
) (
    input  logic                clk,
    input  logic                i_clr,
    input  logic                i_we,
    input  logic [P_ADDR_W-1:0] i_waddr,
    input  logic [P_DATA_W-1:0] i_wdata,
    input  logic [P_ADDR_W-1:0] i_raddr,
    input  logic [P_ADDR_W:0]   i_count,
    output logic [P_DATA_W-1:0] o_rdata
);

    logic [P_DATA_W-1:0] r_mem [P_DEPTH];

    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int unsigned i = 0; i < P_DEPTH; i++) begin
                r_mem[i[P_ADDR_W-1:0]] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Unloaded words read as 0x00 so the CPU sees HLT padding.
    always_comb begin
        o_rdata = '0;
        if ({1'b0, i_raddr} < i_count) begin
            o_rdata = r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: collects a program from the host, walks the CPU control
// block through programming mode to write it into the 16x8 RAM, then resets
// the CPU and lets it run, reporting halt and programming stalls.
//   clk, resetn        clock; synchronous active-low reset
//   start              begin a new load from any state
//   in_valid/in_data/in_last/in_ready   host byte stream (valid/ready)
//   cpu_ready          control block at T0 (not needed for sequencing)
//   cpu_read_ui_in     control block requests the next bus byte
//   cpu_done_load      control block wrote the current RAM word
//   cpu_hf             CPU halt flag
//   programming, cpu_resetn             control outputs to the CPU
//   bus_drive, bus_data                 bus ownership and byte
//   load_count         bytes accepted from the host
//   busy, halted, error                 status
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned P_DEPTH      = DEPTH,
    parameter int unsigned P_ADDR_W     = ADDR_W,
    parameter int unsigned P_DATA_W     = DATA_W,
    parameter int unsigned P_RST_CYCLES = RST_CYCLES,
    parameter int unsigned P_TIMEOUT    = TIMEOUT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                in_valid,
    input  logic [P_DATA_W-1:0] in_data,
    input  logic                in_last,
    output logic                in_ready,
    input  logic                cpu_ready,
    input  logic                cpu_read_ui_in,
    input  logic                cpu_done_load,
    input  logic                cpu_hf,
    output logic                programming,
    output logic                cpu_resetn,
    output logic                bus_drive,
    output logic [P_DATA_W-1:0] bus_data,
    output logic [P_ADDR_W:0]   load_count,
    output logic                busy,
    output logic                halted,
    output logic                error
);

    localparam int unsigned RST_W  = $clog2(P_RST_CYCLES);
    localparam int unsigned WDOG_W = $clog2(P_TIMEOUT);

    state_t              r_state, w_state_nxt;
    logic [P_ADDR_W:0]   r_load_cnt, w_load_cnt_nxt;
    logic [RST_W-1:0]    r_rst_cnt, w_rst_cnt_nxt;
    logic [P_ADDR_W-1:0] r_wr_idx, w_wr_idx_nxt;
    logic [WDOG_W-1:0]   r_wdog, w_wdog_nxt;
    logic                r_in_ready, r_programming, r_cpu_resetn;
    logic                r_busy, r_halted, r_error;
    logic                w_accept, w_clr;
    logic [P_DATA_W-1:0] w_buf_rd;
    logic                w_unused;

    // Word sequencing follows read_ui_in/done_load alone; cpu_ready is kept
    // on the port list for interface compatibility.
    assign w_unused = cpu_ready;

    assign w_accept = (r_state == S_FILL) && in_valid && r_in_ready;

    program_buffer #(
        .P_DEPTH  (P_DEPTH),
        .P_ADDR_W (P_ADDR_W),
        .P_DATA_W (P_DATA_W)
    ) u_buf (
        .clk     (clk),
        .i_clr   (w_clr),
        .i_we    (w_accept && !start),
        .i_waddr (r_load_cnt[P_ADDR_W-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_wr_idx),
        .i_count (r_load_cnt),
        .o_rdata (w_buf_rd)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_load_cnt_nxt = r_load_cnt;
        w_rst_cnt_nxt  = r_rst_cnt;
        w_wr_idx_nxt   = r_wr_idx;
        w_wdog_nxt     = r_wdog;
        w_clr          = 1'b0;
        if (start) begin
            w_state_nxt    = S_FILL;
            w_load_cnt_nxt = '0;
            w_clr          = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_FILL: begin
                    if (w_accept) begin
                        w_load_cnt_nxt = r_load_cnt + 1'b1;
                        if (in_last || r_load_cnt == (P_ADDR_W+1)'(P_DEPTH - 1)) begin
                            w_state_nxt   = S_PRE_RST;
                            w_rst_cnt_nxt = '0;
                        end
                    end
                end
                S_PRE_RST: begin
                    if (r_rst_cnt == RST_W'(P_RST_CYCLES - 1)) begin
                        w_state_nxt  = S_PROGRAM;
                        w_wr_idx_nxt = '0;
                        w_wdog_nxt   = '0;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                    end
                end
                S_PROGRAM: begin
                    if (cpu_done_load) begin
                        w_wdog_nxt = '0;
                        if (r_wr_idx == P_ADDR_W'(P_DEPTH - 1)) begin
                            w_state_nxt   = S_POST_RST;
                            w_rst_cnt_nxt = '0;
                        end else begin
                            w_wr_idx_nxt = r_wr_idx + 1'b1;
                        end
                    end else if (r_wdog == WDOG_W'(P_TIMEOUT - 1)) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_wdog_nxt = r_wdog + 1'b1;
                    end
                end
                S_POST_RST: begin
                    if (r_rst_cnt == RST_W'(P_RST_CYCLES - 1)) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (cpu_hf) begin
                        w_state_nxt = S_HALTED;
                    end
                end
                S_HALTED: ;
                S_ERROR:  ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Status outputs are registered from the next-state decode so they line
    // up with the state they describe rather than lagging it by a cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_load_cnt    <= '0;
            r_rst_cnt     <= '0;
            r_wr_idx      <= '0;
            r_wdog        <= '0;
            r_in_ready    <= 1'b0;
            r_programming <= 1'b0;
            r_cpu_resetn  <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_load_cnt    <= w_load_cnt_nxt;
            r_rst_cnt     <= w_rst_cnt_nxt;
            r_wr_idx      <= w_wr_idx_nxt;
            r_wdog        <= w_wdog_nxt;
            r_in_ready    <= (w_state_nxt == S_FILL) &&
                             (w_load_cnt_nxt < (P_ADDR_W+1)'(P_DEPTH));
            r_programming <= (w_state_nxt == S_PRE_RST) || (w_state_nxt == S_PROGRAM);
            r_cpu_resetn  <= (w_state_nxt == S_PROGRAM) || (w_state_nxt == S_RUN) ||
                             (w_state_nxt == S_HALTED);
            r_busy        <= (w_state_nxt == S_FILL) || (w_state_nxt == S_PRE_RST) ||
                             (w_state_nxt == S_PROGRAM) || (w_state_nxt == S_POST_RST);
            r_halted      <= (w_state_nxt == S_HALTED);
            r_error       <= (w_state_nxt == S_ERROR);
        end
    end

    assign bus_drive   = (r_state == S_PROGRAM) && cpu_read_ui_in;
    assign bus_data    = bus_drive ? w_buf_rd : '0;
    assign in_ready    = r_in_ready;
    assign programming = r_programming;
    assign cpu_resetn  = r_cpu_resetn;
    assign load_count  = r_load_cnt;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign error       = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a simple control-block/RAM model.
module tb_program_loader;
    import loader_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       cpu_ready = 1'b1;
    logic       cpu_read_ui_in = 1'b0;
    logic       cpu_done_load = 1'b0;
    logic       cpu_hf = 1'b0;
    logic       programming, cpu_resetn, bus_drive;
    logic [7:0] bus_data;
    logic [4:0] load_count;
    logic       busy, halted, error;

    logic [7:0] ram [16];
    int         n_cmp = 0;
    int         n_err = 0;
    int         pulses;

    program_loader dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .cpu_ready      (cpu_ready),
        .cpu_read_ui_in (cpu_read_ui_in),
        .cpu_done_load  (cpu_done_load),
        .cpu_hf         (cpu_hf),
        .programming    (programming),
        .cpu_resetn     (cpu_resetn),
        .bus_drive      (bus_drive),
        .bus_data       (bus_data),
        .load_count     (load_count),
        .busy           (busy),
        .halted         (halted),
        .error          (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        @(negedge clk);
        chk("in_ready_fill", in_ready, 1'b1);
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_prog();
        for (int i = 0; i < 10; i++) begin
            if (programming && cpu_resetn) break;
            @(negedge clk);
        end
        chk("wait_program", programming && cpu_resetn, 1'b1);
    endtask

    // Control-block model: request a byte, latch it into ram, pulse done_load.
    task automatic cpu_load(input int stop_after, output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!(programming && cpu_resetn)) break;
            if (k == stop_after) break;
            @(negedge clk); cpu_read_ui_in = 1'b1;
            #1;
            chk("bus_drive_on", bus_drive, 1'b1);
            ram[k % 16] = bus_data;
            @(negedge clk); cpu_read_ui_in = 1'b0; cpu_done_load = 1'b1;
            #1;
            chk("bus_data_idle", {bus_drive, bus_data}, 9'h000);
            @(negedge clk); cpu_done_load = 1'b0;
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] exp3 [16];

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", {in_ready, programming, cpu_resetn, bus_drive, bus_data,
                            load_count, busy, halted, error}, 32'h0);
        resetn = 1'b1;

        // 1: three-byte program, HLT padding, run to halt
        pulse_start();
        chk("t1_fill_ready", {in_ready, busy, load_count}, {1'b1, 1'b1, 5'd0});
        send_byte(8'h4E, 1'b0);
        send_byte(8'h5F, 1'b0);
        send_byte(8'h00, 1'b1);
        chk("t1_pre_rst", {programming, cpu_resetn, busy, in_ready}, 4'b1010);
        chk("t1_load_count", load_count, 5'd3);
        @(negedge clk);
        chk("t1_pre_rst_2nd", cpu_resetn, 1'b0);
        @(negedge clk);
        chk("t1_program_entry", {programming, cpu_resetn}, 2'b11);
        cpu_load(-1, pulses);
        chk("t1_pulses", pulses, 16);
        chk("t1_ram0", ram[0], 8'h4E);
        chk("t1_ram1", ram[1], 8'h5F);
        chk("t1_ram2", ram[2], 8'h00);
        for (int i = 3; i < 16; i++) chk("t1_ram_pad", ram[i], 8'h00);
        chk("t1_post_rst", {programming, cpu_resetn, busy}, 3'b001);
        @(negedge clk);
        chk("t1_post_rst_2nd", cpu_resetn, 1'b0);
        @(negedge clk);
        chk("t1_run", {cpu_resetn, programming, busy, halted}, 4'b1000);
        cpu_hf = 1'b1;
        @(negedge clk);
        cpu_hf = 1'b0;
        chk("t1_halted", {halted, cpu_resetn, busy, error}, 4'b1100);

        // 2: sixteen bytes without in_last, then a rejected 17th
        pulse_start();
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b0);
        chk("t2_ready_drop", in_ready, 1'b0);
        chk("t2_count16", load_count, 5'd16);
        @(negedge clk); in_valid = 1'b1; in_data = 8'hEE;
        @(negedge clk); in_valid = 1'b0;
        chk("t2_17th_rejected", {in_ready, load_count}, {1'b0, 5'd16});
        wait_prog();
        cpu_load(-1, pulses);
        chk("t2_pulses", pulses, 16);
        for (int i = 0; i < 16; i++) chk("t2_ram", ram[i], 8'h10 + 8'(i));

        // 3: in_valid on alternate cycles; only handshaked bytes land
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            in_data  = 8'hA0 + 8'(i);
            in_last  = (i == 6);
        end
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        chk("t3_count", load_count, 5'd4);
        wait_prog();
        cpu_load(-1, pulses);
        chk("t3_pulses", pulses, 16);
        for (int i = 0; i < 16; i++) exp3[i] = 8'h00;
        exp3[0] = 8'hA0; exp3[1] = 8'hA2; exp3[2] = 8'hA4; exp3[3] = 8'hA6;
        for (int i = 0; i < 16; i++) chk("t3_ram", ram[i], exp3[i]);

        // 4: control block stalls after word 5 -> watchdog
        pulse_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        wait_prog();
        cpu_load(6, pulses);
        chk("t4_pulses", pulses, 6);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("t4_before_timeout", {error, programming, cpu_resetn}, 3'b011);
        @(negedge clk);
        chk("t4_error", {error, programming, cpu_resetn, busy}, 4'b1000);

        // 5: start during PROGRAM at word 7
        pulse_start();
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        wait_prog();
        cpu_load(7, pulses);
        chk("t5_pulses", pulses, 7);
        pulse_start();
        chk("t5_restart", {programming, cpu_resetn, busy, in_ready, error},
            5'b00110);
        chk("t5_count0", load_count, 5'd0);

        // 6: reset pulse during RUN
        send_byte(8'h77, 1'b1);
        wait_prog();
        cpu_load(-1, pulses);
        chk("t6_pulses", pulses, 16);
        chk("t6_ram0", ram[0], 8'h77);
        chk("t6_ram1", ram[1], 8'h00);
        for (int i = 0; i < 10; i++) begin
            if (cpu_resetn && !programming && !busy) break;
            @(negedge clk);
        end
        chk("t6_in_run", {cpu_resetn, programming, busy, halted}, 4'b1000);
        resetn = 1'b0;
        @(negedge clk);
        chk("t6_reset_outputs", {in_ready, programming, cpu_resetn, bus_drive, bus_data,
                                 load_count, busy, halted, error}, 32'h0);
        resetn = 1'b1;
        in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_idle_ignores_valid", {in_ready, load_count, busy}, 7'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
